// File: rtl/iir_stage_sched.sv
// iir_stage_sched
//   Time-shares one first-order difference-equation datapath across NST
//   cascaded filter stages, once per incoming audio sample. The block owns
//   each stage's x[n-1] / y[n-1] history and presents one stage at a time
//   to the datapath. After LAT settle cycles it captures the result and
//   chains that result into the next stage. The last stage's result goes
//   to sample_out.
//
//   This block does no arithmetic. Every N-bit word passes through
//   unmodified. Offset handling and saturation belong to the datapath.
//
// Ports
//   clk, reset_n       system clock, asynchronous active-low reset
//   sample_valid       one-cycle strobe, sample_in holds a new x[n]
//   sample_in [N]      input sample, offset-binary
//   f_stage [NST*16]   per-stage cutoff, stage k in bits [16k+15:16k]
//   flush              clear all history to mid-scale (IDLE only)
//   clr_overrun        clear the sticky overrun flag
//   dp_x0/x1/y [N]     datapath operands: x[n], x[n-1], y[n-1]
//   dp_f [16]          datapath cutoff for the current stage
//   dp_type            datapath filter type (0 LPF, 1 HPF)
//   dp_out [N]         datapath result y[n]
//   sample_out [N]     final-stage output, held until the next result
//   out_valid          one-cycle pulse when sample_out updates
//   busy               a sample is in flight
//   overrun            sticky, a sample arrived while busy
module iir_stage_sched #(
    parameter int              N         = 10,
    parameter int              NST       = 2,
    parameter int              LAT       = 1,
    parameter logic [NST-1:0]  TYPE_MASK = 2'b10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_valid,
    input  logic [N-1:0]       sample_in,
    input  logic [NST*16-1:0]  f_stage,
    input  logic               flush,
    input  logic               clr_overrun,
    output logic [N-1:0]       dp_x0,
    output logic [N-1:0]       dp_x1,
    output logic [N-1:0]       dp_y,
    output logic [15:0]        dp_f,
    output logic               dp_type,
    input  logic [N-1:0]       dp_out,
    output logic [N-1:0]       sample_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int KW = (NST > 1) ? $clog2(NST) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [N-1:0]  MID      = {1'b1, {(N-1){1'b0}}};
    localparam logic [KW-1:0] K_LAST   = KW'(NST - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CAPT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [KW-1:0] k;
    logic [CW-1:0] cnt;
    logic [N-1:0]  cur_x;
    logic [N-1:0]  xhist [NST];
    logic [N-1:0]  yhist [NST];
    logic [15:0]   f_arr [NST];

    // A new sample is taken from IDLE, or from DONE so that samples can run
    // back to back.
    logic accept;
    assign accept = sample_valid && (state == S_IDLE || state == S_DONE);

    // NOTE: every output of an always_comb must be assigned on every path.
    // Here the loop covers each element, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NST; i++) begin
            f_arr[i] = f_stage[16*i +: 16];
        end
    end

    // The datapath operands always reflect stage k. They only matter during
    // ISSUE. During CAPT they are held, so dp_out stays valid at the capture
    // edge.
    assign dp_x0   = cur_x;
    assign dp_x1   = xhist[k];
    assign dp_y    = yhist[k];
    assign dp_f    = f_arr[k];
    assign dp_type = TYPE_MASK[k];

    assign busy      = (state == S_ISSUE) || (state == S_CAPT);
    assign out_valid = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers therefore update together from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            k          <= '0;
            cnt        <= '0;
            cur_x      <= MID;
            sample_out <= MID;
            // NOTE: the history arrays are reset explicitly. Mid-scale is
            // audio silence, so the first sample after reset filters against
            // a silent past rather than against power-up garbage.
            for (int i = 0; i < NST; i++) begin
                xhist[i] <= MID;
                yhist[i] <= MID;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // Flush is only honoured in IDLE. When it coincides with
                    // a new sample, that sample runs against the cleared
                    // history. The history is not read until ISSUE.
                    if (state == S_IDLE && flush) begin
                        for (int i = 0; i < NST; i++) begin
                            xhist[i] <= MID;
                            yhist[i] <= MID;
                        end
                    end
                    if (accept) begin
                        cur_x <= sample_in;
                        k     <= '0;
                        cnt   <= '0;
                        state <= S_ISSUE;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_ISSUE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= S_CAPT;
                    end
                end

                S_CAPT: begin
                    xhist[k] <= cur_x;
                    yhist[k] <= dp_out;
                    // This stage's y[n] becomes the next stage's x[n].
                    cur_x    <= dp_out;
                    if (k == K_LAST) begin
                        sample_out <= dp_out;
                        state      <= S_DONE;
                    end else begin
                        k     <= k + KW'(1);
                        cnt   <= '0;
                        state <= S_ISSUE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Overrun flag. A sample dropped because it arrived mid-computation sets
    // the flag, and this takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (sample_valid && busy) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iir_stage_sched.sv
// tb_iir_stage_sched
//   Directed bench for iir_stage_sched. The main instance uses N=10, NST=2,
//   LAT=1. A second instance uses NST=3, LAT=3 and covers the longer
//   latency. Both datapaths are stubbed as dp_out = dp_x0 + 1, so every
//   expected value can be worked out by hand.
module tb_iir_stage_sched;

    localparam int N = 10;

    logic clk;
    logic reset_n;

    // Main instance: NST=2, LAT=1
    logic          sample_valid;
    logic [N-1:0]  sample_in;
    logic [31:0]   f_stage;
    logic          flush;
    logic          clr_overrun;
    logic [N-1:0]  dp_x0, dp_x1, dp_y, dp_out, sample_out;
    logic [15:0]   dp_f;
    logic          dp_type, out_valid, busy, overrun;

    // Second instance: NST=3, LAT=3
    localparam logic [2:0] TYPE3 = 3'b010;
    logic          sample_valid_3;
    logic [N-1:0]  sample_in_3;
    logic [47:0]   f_stage_3;
    logic [N-1:0]  dp_x0_3, dp_x1_3, dp_y_3, dp_out_3, sample_out_3;
    logic [15:0]   dp_f_3;
    logic          dp_type_3, out_valid_3, busy_3, overrun_3;

    int n_checks = 0;
    int n_fail   = 0;

    assign dp_out   = dp_x0 + 10'd1;
    assign dp_out_3 = dp_x0_3 + 10'd1;

    iir_stage_sched #(.N(N), .NST(2), .LAT(1), .TYPE_MASK(2'b10)) dut (
        .clk(clk), .reset_n(reset_n),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .f_stage(f_stage), .flush(flush), .clr_overrun(clr_overrun),
        .dp_x0(dp_x0), .dp_x1(dp_x1), .dp_y(dp_y), .dp_f(dp_f),
        .dp_type(dp_type), .dp_out(dp_out),
        .sample_out(sample_out), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    iir_stage_sched #(.N(N), .NST(3), .LAT(3), .TYPE_MASK(TYPE3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .sample_valid(sample_valid_3), .sample_in(sample_in_3),
        .f_stage(f_stage_3), .flush(1'b0), .clr_overrun(1'b0),
        .dp_x0(dp_x0_3), .dp_x1(dp_x1_3), .dp_y(dp_y_3), .dp_f(dp_f_3),
        .dp_type(dp_type_3), .dp_out(dp_out_3),
        .sample_out(sample_out_3), .out_valid(out_valid_3),
        .busy(busy_3), .overrun(overrun_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One active edge, then settle 1 time unit so that outputs are sampled
    // away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [N-1:0] s);
        sample_in    = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    // Counts edges until out_valid is seen. The count is bounded, and an
    // expired bound shows up as a wrong latency in the caller's check.
    task automatic wait_out(input int budget, output int lat);
        lat = 0;
        while (!out_valid && lat < budget) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;

        reset_n        = 1'b0;
        sample_valid   = 1'b0;
        sample_in      = '0;
        f_stage        = {16'd2000, 16'd500};
        flush          = 1'b0;
        clr_overrun    = 1'b0;
        sample_valid_3 = 1'b0;
        sample_in_3    = '0;
        f_stage_3      = {16'd3, 16'd2, 16'd1};
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // 1. Reset state and basic sequencing
        check("rst_sample_out", sample_out, 512);
        check("rst_out_valid",  out_valid, 0);
        check("rst_busy",       busy, 0);
        check("rst_overrun",    overrun, 0);
        check("rst_dp_x0",      dp_x0, 512);

        accept(10'd300);
        check("t1_busy", busy, 1);
        wait_out(20, lat);
        check("t1_latency",   lat, 4);
        check("t1_sample_out", sample_out, 302);
        check("t1_xhist0", dut.xhist[0], 300);
        check("t1_xhist1", dut.xhist[1], 301);
        check("t1_yhist0", dut.yhist[0], 301);
        check("t1_yhist1", dut.yhist[1], 302);
        tick();
        check("t1_pulse_width", out_valid, 0);

        // 2. History chaining, per-stage operands
        accept(10'd100);
        check("t2_s0_dp_x0",   dp_x0, 100);
        check("t2_s0_dp_x1",   dp_x1, 300);
        check("t2_s0_dp_y",    dp_y, 301);
        check("t2_s0_dp_f",    dp_f, 500);
        check("t2_s0_dp_type", dp_type, 0);
        tick();
        tick();
        check("t2_s1_dp_x0",   dp_x0, 101);
        check("t2_s1_dp_x1",   dp_x1, 301);
        check("t2_s1_dp_y",    dp_y, 302);
        check("t2_s1_dp_f",    dp_f, 2000);
        check("t2_s1_dp_type", dp_type, 1);
        tick();
        tick();
        check("t2_out_valid",  out_valid, 1);
        check("t2_sample_out", sample_out, 102);
        tick();

        // 3. Overrun set / clear / priority
        accept(10'd200);
        tick();
        sample_in    = 10'd999;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("t3_overrun_set", overrun, 1);
        wait_out(20, lat);
        check("t3_latency",    lat, 2);
        check("t3_sample_out", sample_out, 202);
        tick();
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("t3_overrun_clr", overrun, 0);
        accept(10'd50);
        sample_in    = 10'd77;
        sample_valid = 1'b1;
        clr_overrun  = 1'b1;
        tick();
        sample_valid = 1'b0;
        clr_overrun  = 1'b0;
        check("t3_set_wins", overrun, 1);
        wait_out(20, lat);
        check("t3b_latency",    lat, 3);
        check("t3b_sample_out", sample_out, 52);
        tick();
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;

        // 4. Back-to-back acceptance from DONE
        accept(10'd10);
        wait_out(20, lat);
        check("t4_first_lat", lat, 4);
        check("t4_first_out", sample_out, 12);
        accept(10'd20);
        check("t4_busy",      busy, 1);
        check("t4_overrun",   overrun, 0);
        check("t4_out_valid", out_valid, 0);
        wait_out(20, lat);
        check("t4_second_lat", lat, 4);
        check("t4_second_out", sample_out, 22);
        tick();

        // 5. Flush in IDLE, flush while busy / DONE, flush with sample
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flush_x0", dut.xhist[0], 512);
        check("t5_flush_x1", dut.xhist[1], 512);
        check("t5_flush_y0", dut.yhist[0], 512);
        check("t5_flush_y1", dut.yhist[1], 512);
        check("t5_flush_out", sample_out, 22);

        accept(10'd40);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_busy_flush_x0", dut.xhist[0], 40);
        check("t5_busy_flush_y0", dut.yhist[0], 41);
        tick();
        check("t5_out_valid", out_valid, 1);
        check("t5_sample_out", sample_out, 42);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_done_flush_x1", dut.xhist[1], 41);
        check("t5_done_flush_y1", dut.yhist[1], 42);
        check("t5_done_flush_x0", dut.xhist[0], 40);

        flush = 1'b1;
        accept(10'd60);
        flush = 1'b0;
        check("t5_fs_dp_x0", dp_x0, 60);
        check("t5_fs_dp_x1", dp_x1, 512);
        check("t5_fs_dp_y",  dp_y, 512);
        wait_out(20, lat);
        check("t5_fs_latency", lat, 4);
        check("t5_fs_out",     sample_out, 62);
        tick();

        // Reset while a sample is in flight
        accept(10'd70);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("t5_pre_rst_overrun", overrun, 1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy",       busy, 0);
        check("t5_rst_out_valid",  out_valid, 0);
        check("t5_rst_sample_out", sample_out, 512);
        check("t5_rst_overrun",    overrun, 0);
        check("t5_rst_xhist0",     dut.xhist[0], 512);
        tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        check("t5_no_pulse_after_rst", pulses, 0);

        // 6. NST=3, LAT=3: three ISSUE cycles per stage, 12-cycle latency
        sample_in_3    = 10'd5;
        sample_valid_3 = 1'b1;
        tick();
        sample_valid_3 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < 3; c++) begin
                check("t6_dp_f",    dp_f_3, 32'(s + 1));
                check("t6_dp_x0",   dp_x0_3, 32'(5 + s));
                check("t6_dp_type", dp_type_3, 32'(TYPE3[s]));
                check("t6_not_done", out_valid_3, 0);
                tick();
            end
            check("t6_capt_busy", busy_3, 1);
            tick();
        end
        check("t6_out_valid",  out_valid_3, 1);
        check("t6_sample_out", sample_out_3, 8);
        tick();
        check("t6_pulse_width", out_valid_3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_stage_sched.md
Name: iir_stage_sched

Overview:
- Sequences a single shared first-order difference-equation datapath across NST cascaded filter stages (e.g. LPF then HPF) once per audio sample.
- Owns the per-stage history registers x[n-1] and y[n-1] and drives the datapath's inputs.
- Captures each stage's result after a fixed settle time and chains it into the next stage.
- Sits between the ADC sample strobe and the DAC/output register.

Parameters:
N, 10, sample/data width in bits, offset-binary (mid-scale 2^(N-1) = silence)
NST, 2, number of cascaded stages time-shared on the datapath (1..8)
LAT, 1, clock cycles the datapath needs to settle after its inputs change (>=1)
TYPE_MASK, 2'b10, bit k = filter type of stage k (0 LPF, 1 HPF)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sample_valid  in  1  one-cycle strobe: new input sample present
sample_in  in  N  input sample x[n], offset-binary
f_stage  in  NST*16  cutoff frequency per stage; stage k in bits [16k+15:16k]
flush  in  1  clear all history to mid-scale (honoured only when idle)
clr_overrun  in  1  clears overrun flag
dp_x0  out  N  datapath x[n]
dp_x1  out  N  datapath x[n-1]
dp_y  out  N  datapath y[n-1]
dp_f  out  16  datapath cutoff
dp_type  out  1  datapath filter type
dp_out  in  N  datapath result y[n]
sample_out  out  N  final-stage output, held until next result
out_valid  out  1  one-cycle pulse: sample_out updated
busy  out  1  high while a sample is being processed
overrun  out  1  sticky: a sample arrived while busy

Behaviour:
- Reset (async, reset_n=0): state IDLE, stage index k=0, settle counter 0.
- Reset values: every xhist[k], yhist[k], cur_x, sample_out = 2^(N-1); out_valid=0, busy=0, overrun=0.
- dp_* outputs are combinational from registered state: dp_x0=cur_x, dp_x1=xhist[k], dp_y=yhist[k], dp_f=f_stage[k], dp_type=TYPE_MASK[k].
- Outside ISSUE, dp_* still reflect stage k; their value there is don't-care.
- States: IDLE, ISSUE, CAPT, DONE.
- IDLE/DONE, sample_valid=1: cur_x<=sample_in, k<=0, settle counter<=0, go ISSUE.
- IDLE/DONE, no sample: DONE always returns to IDLE after its single cycle.
- ISSUE: counter increments each cycle; after LAT cycles in ISSUE go CAPT.
- CAPT (one cycle):
  - xhist[k]<=cur_x, yhist[k]<=dp_out, cur_x<=dp_out.
  - If k==NST-1: sample_out<=dp_out, go DONE. Else k<=k+1, counter<=0, go ISSUE.
- out_valid=1 only in DONE.
- Latency: with the accepting edge E0, out_valid is high for exactly one cycle starting at edge E0+NST*(LAT+1). Example: NST=2, LAT=1 gives 4 cycles.
- busy=1 in ISSUE and CAPT; 0 in IDLE and DONE. Back-to-back acceptance from DONE is allowed.
- sample_valid while busy: the sample is dropped, overrun<=1, and the in-flight computation is unaffected.
- clr_overrun=1 clears overrun. Same cycle as a new overrun event: set wins.
- flush in IDLE: all xhist/yhist<=2^(N-1), sample_out unchanged.
- flush while busy or in DONE: ignored.
- flush and sample_valid together in IDLE: flush applies first, then the sample is accepted using the cleared history.
- No arithmetic in this block. All data is N-bit and passed unmodified; no saturation or offset handling (that is the datapath's job).
- f_stage is sampled live during ISSUE and must be stable across ISSUE.
- Reset mid-operation: returns immediately to reset values; no out_valid pulse is produced for the aborted sample.

Test Plan:
1. Sequencing, N=10, NST=2, LAT=1, stub dp_out = dp_x0 + 1: reset, then sample_in=300 -> out_valid exactly 4 cycles after accept, sample_out=302. xhist={300,301}, yhist={301,302}.
2. History chaining, same stub, f_stage={16'd2000,16'd500}: second sample 100. During stage-0 ISSUE dp_x1=300, dp_y=301, dp_f=500, dp_type=0. During stage-1 ISSUE dp_x1=301, dp_y=302, dp_f=2000, dp_type=1. Result sample_out=102.
3. Overrun: sample_valid with 200 accepted, second sample_valid 2 cycles later -> overrun=1, sample_out=202 (the second sample is ignored). clr_overrun -> overrun=0. clr_overrun and a new overrun in the same cycle -> overrun stays 1.
4. Back-to-back: sample_valid asserted in the DONE cycle -> accepted, busy=1 next cycle, overrun stays 0, two out_valid pulses 4 cycles apart.
5. Flush and reset: after activity, flush in IDLE -> all history 512 and sample_out unchanged. flush while busy -> no change. reset_n low during ISSUE -> outputs at reset values immediately, no out_valid.
6. LAT=3, NST=3: sample accepted -> out_valid 12 cycles later. dp_* are stable for exactly 3 cycles per stage.
